// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified I/D memory front end (mem_port_arbiter).
// Holds the FSM state encodings, the funct3 width codes and the lane positions
// of byte and halfword data inside the memory read word.
package mem_arb_pkg;

  // FSM states: which result, if any, comes back from memory this cycle.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GNT_IF = 2'd1;
  localparam logic [1:0] ST_GNT_DM = 2'd2;

  typedef logic [2:0] funct3_t;

  // Load/store width codes (funct3).
  localparam funct3_t F3_B  = 3'b000;
  localparam funct3_t F3_H  = 3'b001;
  localparam funct3_t F3_W  = 3'b010;
  localparam funct3_t F3_BU = 3'b100;
  localparam funct3_t F3_HU = 3'b101;

  // The addressed byte/halfword is delivered in the top lanes of mem_rdata.
  localparam int BYTE_LANE_LSB = 24;
  localparam int HALF_LANE_LSB = 16;

endpackage

// File: rtl/mem_port_arbiter_load_extend.sv
// load_extend: combinational load-result formatter for mem_port_arbiter.
// Picks the byte or halfword lane and sign/zero-extends it according to funct3.
// Only instantiated when MEMARB_LOAD_EXT_EN is defined.
module load_extend
  import mem_arb_pkg::*;
(
  input  logic [2:0]  func,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[31:BYTE_LANE_LSB];
  assign half_lane = rdata[31:HALF_LANE_LSB];

  // Select and extend the lane named by funct3; unknown codes return the raw word.
  always_comb begin
    // NOTE: default assignment first so every path drives rdata_ext and no latch is inferred.
    rdata_ext = rdata;
    case (func)
      F3_B:    rdata_ext = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    rdata_ext = {{16{half_lane[15]}}, half_lane};
      F3_BU:   rdata_ext = {24'h0, byte_lane};
      F3_HU:   rdata_ext = {16'h0, half_lane};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: front end of the shared single-port instruction/data memory.
// Grants at most one of the IF fetch and the MEM load/store each cycle, stalls the
// loser, and returns instruction / load data one cycle after the grant.
// Data normally wins; after STARVE_MAX consecutive data grants with a fetch
// waiting, the fetch is forced through.
// Build option: MEMARB_LOAD_EXT_EN -- when defined, loads are sign/zero-extended
// here; otherwise dm_rdata is the raw memory word and the extension happens later.
//
// A requester may present its next request in the same cycle its previous result
// pulses (if_valid / dm_done), so a held request line yields one result per cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int STARVE_MAX = 3   // must be >= 1
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_stall,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_func,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic              dm_stall,
  output logic              dm_done,
  output logic [31:0]       dm_rdata,
  // memory port
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [2:0]        mem_func,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] starve_cnt_q;
  logic             store_done_q;
  logic [31:0]      if_instr_q;
  logic [31:0]      dm_rdata_q;
  logic [31:0]      dm_rdata_next;
  logic             gnt_if;
  logic             gnt_dm;

  // Arbitration: data first unless the fetch has been starved STARVE_MAX times.
  always_comb begin
    gnt_if = 1'b0;
    gnt_dm = 1'b0;
    if (!rst) begin
      if (dm_req && !(if_req && (starve_cnt_q == STARVE_LIM))) begin
        gnt_dm = 1'b1;
      end else if (if_req) begin
        gnt_if = 1'b1;
      end
    end
  end

  // Memory strobes, address and width follow the grant combinationally.
  assign mem_read  = gnt_if | (gnt_dm & ~dm_we);
  assign mem_write = gnt_dm & dm_we;
  assign mem_addr  = gnt_if ? if_addr : (gnt_dm ? dm_addr : '0);
  assign mem_func  = gnt_if ? F3_W : (gnt_dm ? dm_func : 3'b000);
  assign mem_wdata = mem_write ? dm_wdata : 32'h0;

  // A waiting request stalls in the same cycle it loses (or is still ungranted).
  assign if_stall = if_req & ~gnt_if & ~rst;
  assign dm_stall = dm_req & ~gnt_dm & ~rst;

  // Result pulses come straight from the state flops; the data registers hold the
  // last result and the arriving word is forwarded during the pulse cycle.
  assign if_valid = (state_q == ST_GNT_IF);
  assign if_instr = if_valid ? mem_rdata : if_instr_q;
  assign dm_done  = (state_q == ST_GNT_DM) | store_done_q;
  assign dm_rdata = (state_q == ST_GNT_DM) ? dm_rdata_next : dm_rdata_q;

  // FSM, store-completion flag and starvation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
      store_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      store_done_q <= gnt_dm & dm_we;
      if (gnt_if) begin
        state_q <= ST_GNT_IF;
      end else if (gnt_dm && !dm_we) begin
        state_q <= ST_GNT_DM;
      end else begin
        state_q <= ST_IDLE;
      end

      if (gnt_if) begin
        starve_cnt_q <= '0;
      end else if (gnt_dm && if_req && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_q <= starve_cnt_q + 1'b1;
      end
    end
  end

  // Result registers: capture the returning word at the end of its pulse cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the result registers are reset because their value is visible on the ports after reset.
      if_instr_q <= 32'h0;
      dm_rdata_q <= 32'h0;
    end else begin
      if (state_q == ST_GNT_IF) if_instr_q <= mem_rdata;
      if (state_q == ST_GNT_DM) dm_rdata_q <= dm_rdata_next;
    end
  end

`ifdef MEMARB_LOAD_EXT_EN
  logic [2:0] dm_func_q;

  // Keep the load's width code: the requester may change dm_func while data returns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dm_func_q <= 3'b000;
    end else if (gnt_dm) begin
      dm_func_q <= dm_func;
    end
  end

  load_extend u_load_extend (
    .func      (dm_func_q),
    .rdata     (mem_rdata),
    .rdata_ext (dm_rdata_next)
  );
`else
  assign dm_rdata_next = mem_rdata;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: table of single transactions plus hand-written
// sequences for reset, fetch starvation and reset during a load. Expected results
// go to per-port queues when requests are driven and are popped on if_valid/dm_done.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 9;
  localparam int STARVE_MAX = 3;

`ifdef MEMARB_LOAD_EXT_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  localparam logic [1:0] K_FETCH = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic [2:0]        func;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       exp;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_stall;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic              dm_req;
  logic              dm_we;
  logic [2:0]        dm_func;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic              dm_stall;
  logic              dm_done;
  logic [31:0]       dm_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        mem_func;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] last_dm;
  logic [31:0] mem[0:127];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_stall  (if_stall),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_func   (dm_func),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_stall  (dm_stall),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_func  (mem_func),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous word memory: read data appears the cycle after mem_read.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
      mem_rdata <= 32'h0;
    end else begin
      if (mem_write) mem[mem_addr[8:2]] <= mem_wdata;
      if (mem_read)  mem_rdata <= mem[mem_addr[8:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] f, input logic [31:0] w);
    logic [31:0] ext;
    case (f)
      3'b000:  ext = {{24{w[31]}}, w[31:24]};
      3'b001:  ext = {{16{w[31]}}, w[31:16]};
      3'b100:  ext = {24'h0, w[31:24]};
      3'b101:  ext = {16'h0, w[31:16]};
      default: ext = w;
    endcase
    return EXT_EN ? ext : w;
  endfunction

  // Scoreboard: compare returned data against the queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid) begin
        check("if_sb_nonempty", 32'(if_q.size() != 0), 32'd1);
        if (if_q.size() != 0) check("if_instr", if_instr, if_q.pop_front());
      end
      if (dm_done) begin
        check("dm_sb_nonempty", 32'(dm_q.size() != 0), 32'd1);
        if (dm_q.size() != 0) check("dm_rdata", dm_rdata, dm_q.pop_front());
      end
    end
  end

  // One isolated transaction: check the grant cycle, then the result pulse.
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    if (v.kind == K_FETCH) begin
      if_req  = 1'b1;
      if_addr = v.addr;
      if_q.push_back(v.exp);
    end else begin
      dm_req   = 1'b1;
      dm_we    = (v.kind == K_STORE);
      dm_func  = v.func;
      dm_addr  = v.addr;
      dm_wdata = v.wdata;
      dm_q.push_back(v.exp);
    end
    @(negedge clk);
    check("grant_addr",  32'(mem_addr),  32'(v.addr));
    check("grant_read",  32'(mem_read),  32'(v.kind != K_STORE));
    check("grant_write", 32'(mem_write), 32'(v.kind == K_STORE));
    check("grant_func",  32'(mem_func),  32'((v.kind == K_FETCH) ? F3_W : v.func));
    check("grant_stall", 32'({if_stall, dm_stall}), 32'd0);
    if (v.kind == K_STORE) check("grant_wdata", mem_wdata, v.wdata);
    @(posedge clk); #1;
    if_req = 1'b0;
    dm_req = 1'b0;
    dm_we  = 1'b0;
    @(negedge clk);
    check("result_pulse", 32'((v.kind == K_FETCH) ? if_valid : dm_done), 32'd1);
    check("strobes_idle", 32'({mem_read, mem_write}), 32'd0);
  endtask

  vec_t vecs[14];

  initial begin
    rst = 1'b1; if_req = 1'b1; if_addr = 9'h008;
    dm_req = 1'b0; dm_we = 1'b0; dm_func = 3'b000; dm_addr = '0; dm_wdata = 32'h0;
    last_dm = 32'h0;

    vecs[0]  = '{K_STORE, F3_W,   9'h004, 32'h0000C0B7, 32'h0};
    vecs[1]  = '{K_STORE, F3_W,   9'h100, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{K_STORE, F3_W,   9'h010, 32'h80017F00, 32'h0};
    vecs[3]  = '{K_STORE, F3_W,   9'h020, 32'h7FFF1234, 32'h0};
    vecs[4]  = '{K_FETCH, F3_W,   9'h004, 32'h0, 32'h0000C0B7};
    vecs[5]  = '{K_LOAD,  F3_W,   9'h100, 32'h0, ld_model(F3_W,  32'hDEADBEEF)};
    vecs[6]  = '{K_LOAD,  F3_B,   9'h010, 32'h0, ld_model(F3_B,  32'h80017F00)};
    vecs[7]  = '{K_LOAD,  F3_BU,  9'h010, 32'h0, ld_model(F3_BU, 32'h80017F00)};
    vecs[8]  = '{K_LOAD,  F3_H,   9'h010, 32'h0, ld_model(F3_H,  32'h80017F00)};
    vecs[9]  = '{K_LOAD,  F3_HU,  9'h010, 32'h0, ld_model(F3_HU, 32'h80017F00)};
    vecs[10] = '{K_LOAD,  F3_B,   9'h020, 32'h0, ld_model(F3_B,  32'h7FFF1234)};
    vecs[11] = '{K_LOAD,  F3_H,   9'h020, 32'h0, ld_model(F3_H,  32'h7FFF1234)};
    vecs[12] = '{K_LOAD,  3'b011, 9'h010, 32'h0, 32'h80017F00};
    vecs[13] = '{K_FETCH, F3_W,   9'h1FC, 32'h0, 32'h0};

    // Reset with a fetch pending: everything quiet, then the fetch goes first.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_if_stall",  32'(if_stall),  32'd0);
    check("rst_if_valid",  32'(if_valid),  32'd0);
    check("rst_if_instr",  if_instr,       32'h0);
    check("rst_dm_flags",  32'({dm_stall, dm_done}), 32'd0);
    check("rst_dm_rdata",  dm_rdata,       32'h0);
    check("rst_mem_ctl",   32'({mem_read, mem_write, mem_func}), 32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_mem_wdata", mem_wdata,      32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    if_q.push_back(32'h0);
    @(negedge clk);
    check("post_rst_read", 32'(mem_read), 32'd1);
    check("post_rst_addr", 32'(mem_addr), 32'h008);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(if_valid), 32'd1);

    // Table of single transactions; a store leaves dm_rdata at the last load value.
    for (int i = 0; i < 14; i++) begin
      vec_t v;
      v = vecs[i];
      if (v.kind == K_STORE) v.exp = last_dm;
      else if (v.kind == K_LOAD) last_dm = v.exp;
      run_vec(v);
    end

    // Both ports held: three data grants, then the starved fetch is forced.
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 9'h004;
    dm_req = 1'b1; dm_we = 1'b0; dm_func = F3_W; dm_addr = 9'h100;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) dm_q.push_back(32'hDEADBEEF);
      else       if_q.push_back(32'h0000C0B7);
      @(negedge clk);
      check("starve_if_stall", 32'(if_stall), 32'(c != 3));
      check("starve_dm_stall", 32'(dm_stall), 32'(c == 3));
      check("starve_addr",     32'(mem_addr), (c == 3) ? 32'h004 : 32'h100);
      @(posedge clk); #1;
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    @(negedge clk);
    check("starve_if_valid", 32'(if_valid), 32'd1);
    last_dm = 32'hDEADBEEF;

    // Reset in the cycle the load result would return: it is dropped.
    @(posedge clk); #1;
    dm_req = 1'b1; dm_we = 1'b0; dm_func = F3_W; dm_addr = 9'h100;
    @(negedge clk);
    check("rst6_grant", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    dm_req = 1'b0;
    @(negedge clk);
    check("rst6_no_done",  32'(dm_done),  32'd0);
    check("rst6_rdata",    dm_rdata,      32'h0);
    check("rst6_no_valid", 32'(if_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    last_dm = 32'h0;
    run_vec('{K_STORE, F3_W, 9'h040, 32'h12345678, 32'h0});
    run_vec('{K_LOAD,  F3_W, 9'h040, 32'h0, ld_model(F3_W, 32'h12345678)});

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("if_sb_drain", 32'(if_q.size()), 32'd0);
    check("dm_sb_drain", 32'(dm_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
